fetch_sequencer: RTL

Instruction-fetch controller for the five-stage pipeline. It drives the address input of the synchronous instruction memory and consumes its one-cycle-latency data output. On reset release it loads a 21-bit reset vector from words 0 and 1, then streams sequential fetches. It assembles one- and two-word instructions, honours pipeline stall and branch/jump redirects, and presents registered instructions to the decode stage.

---
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory port and the fetch/decode handshake of fetch_sequencer.
// master = fetch controller side, slave = memory/decode/bench side.
interface fetch_sequencer_if #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 21
);
    logic [ADDRESS_SPACE-1:0]   mar;
    logic [WORD_LENGTH-1:0]     mdr;
    logic                       stall;
    logic                       redirect;
    logic [ADDRESS_SPACE-1:0]   redirect_pc;
    logic [2*WORD_LENGTH-1:0]   instr;
    logic [ADDRESS_SPACE-1:0]   instr_pc;
    logic                       instr_valid;
    logic                       booting;

    modport master (
        output mar,
        input  mdr,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr,
        output instr_pc,
        output instr_valid,
        output booting
    );

    modport slave (
        input  mar,
        output mdr,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        input  booting
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: boots from the reset vector in words 0/1, then streams
// sequential fetches, assembling one- and two-word instructions for decode.
module fetch_sequencer #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 21
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    localparam int VH = ADDRESS_SPACE - WORD_LENGTH;

    typedef enum logic [2:0] {VEC0, VEC1, VEC2, RUN, IMM} state_t;

    state_t state;
    state_t state_next;

    logic [ADDRESS_SPACE-1:0]  pc;
    logic [ADDRESS_SPACE-1:0]  pend_addr;
    logic                      pend_valid;
    logic [WORD_LENGTH-1:0]    hold_word;
    logic [ADDRESS_SPACE-1:0]  hold_pc;
    logic [VH-1:0]             vec_hi;
    logic [2*WORD_LENGTH-1:0]  instr_r;
    logic [ADDRESS_SPACE-1:0]  instr_pc_r;
    logic                      instr_valid_r;

    logic running;
    logic issue;
    logic consume;
    logic two_word;

    always_comb begin
        running  = (state == RUN) || (state == IMM);
        issue    = running && !bus.stall && !bus.redirect;
        consume  = issue && pend_valid;
        two_word = bus.mdr[WORD_LENGTH-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= VEC0;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            VEC0: state_next = VEC1;
            VEC1: state_next = VEC2;
            VEC2: state_next = RUN;
            RUN: begin
                if (bus.redirect)            state_next = RUN;
                else if (consume && two_word) state_next = IMM;
            end
            IMM: begin
                if (bus.redirect)  state_next = RUN;
                else if (consume)  state_next = RUN;
            end
            default: state_next = VEC0;
        endcase
    end

    // A stalled fetch re-presents pend_addr so mdr still holds that word on release.
    always_comb begin
        bus.mar     = '0;
        bus.booting = 1'b0;
        case (state)
            VEC0: begin
                bus.mar     = '0;
                bus.booting = 1'b1;
            end
            VEC1, VEC2: begin
                bus.mar     = ADDRESS_SPACE'(1);
                bus.booting = 1'b1;
            end
            RUN, IMM: begin
                if (bus.stall && !bus.redirect) bus.mar = pend_addr;
                else                            bus.mar = pc;
            end
            default: bus.booting = 1'b1;
        endcase
        if (!reset) bus.mar = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= '0;
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            hold_word     <= '0;
            hold_pc       <= '0;
            vec_hi        <= '0;
            instr_r       <= '0;
            instr_pc_r    <= '0;
            instr_valid_r <= 1'b0;
        end else begin
            case (state)
                VEC1: vec_hi <= bus.mdr[VH-1:0];
                VEC2: pc <= {vec_hi, bus.mdr};
                RUN, IMM: begin
                    if (bus.redirect) begin
                        pc            <= bus.redirect_pc;
                        pend_valid    <= 1'b0;
                        instr_valid_r <= 1'b0;
                    end else if (!bus.stall) begin
                        pc         <= pc + ADDRESS_SPACE'(1);
                        pend_valid <= 1'b1;
                        pend_addr  <= pc;
                        if (!pend_valid) begin
                            instr_valid_r <= 1'b0;
                        end else if (state == IMM) begin
                            instr_r       <= {hold_word, bus.mdr};
                            instr_pc_r    <= hold_pc;
                            instr_valid_r <= 1'b1;
                        end else if (two_word) begin
                            hold_word     <= bus.mdr;
                            hold_pc       <= pend_addr;
                            instr_valid_r <= 1'b0;
                        end else begin
                            instr_r       <= {bus.mdr, {WORD_LENGTH{1'b0}}};
                            instr_pc_r    <= pend_addr;
                            instr_valid_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.instr_valid = instr_valid_r;
endmodule
